// File: rtl/aes_pkg.sv
// Shared AES definitions: block/word types, FSM encoding, GF(2^8) helpers and S-boxes.
// S-boxes are computed from the field inverse plus the affine map, not stored as tables.
package aes_pkg;

   typedef logic [3:0][3:0][7:0] state_t;  // [row][col][bit]
   typedef logic [31:0]          word_t;
   typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} fsm_t;

   localparam int NR = 10;
   localparam logic [7:0] RCON [0:15] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                         8'h40, 8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00,
                                         8'h00, 8'h00};

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8); zero maps to zero.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gmul(r, r);
         if (i != 0) r = gmul(r, a);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
      logic [15:0] d;
      d = {a, a};
      return d[15-n -: 8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
   endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Block-level bus of the iterative AES-128 decryption core.
interface aes_inv_cipher_iter_if;
   import aes_pkg::*;

   // Both channels are valid/ready: a transfer happens on a rising clk edge where valid and
   // ready are both high; the source holds valid and data until that edge.
   logic   in_valid;
   logic   in_ready;
   state_t ciphertext;
   state_t last_key;
   logic   out_valid;
   logic   out_ready;
   state_t plaintext;

   modport master (output in_valid, ciphertext, last_key, out_ready,
                   input  in_ready, out_valid, plaintext);
   modport slave  (input  in_valid, ciphertext, last_key, out_ready,
                   output in_ready, out_valid, plaintext);
endinterface

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round.
module aes_inv_round
   import aes_pkg::*;
(
   input  state_t state,
   input  state_t rk,
   input  logic   last,
   output state_t next_state
);

   state_t t;

   always_comb begin
      t          = '0;
      next_state = '0;
      // Row r rotates right by r, so the byte landing in column c came from column c-r.
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            t[r][c] = inv_sbox(state[r][2'(c - r)]) ^ rk[r][c];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            next_state[r][c] = last ? t[r][c] :
                               gmul(t[r][c], 8'h0e)          ^ gmul(t[2'(r + 1)][c], 8'h0b) ^
                               gmul(t[2'(r + 2)][c], 8'h0d)  ^ gmul(t[2'(r + 3)][c], 8'h09);
   end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption: one inverse round per clock, round keys 9..0 derived
// on the fly from the round-10 key by running the key schedule backwards.
module aes_inv_cipher_iter
   import aes_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   aes_inv_cipher_iter_if.slave  bus,
   output fsm_t                  dbg_state
);

   fsm_t       fsm_q, fsm_d;
   state_t     st_q, st_d;
   state_t     rk_q, rk_d;
   state_t     pt_q, pt_d;
   logic [3:0] rnd_q, rnd_d;
   logic       ready_q;
   logic       in_ready_w;
   state_t     round_out;

   // Undo one schedule step: recover words 3..1 by XOR, then word 0 via RotWord/SubWord.
   function automatic state_t inv_key_step(input state_t w, input logic [7:0] rc);
      state_t p;
      p = w;
      for (int r = 0; r < 4; r++) begin
         p[r][3] = w[r][3] ^ w[r][2];
         p[r][2] = w[r][2] ^ w[r][1];
         p[r][1] = w[r][1] ^ w[r][0];
      end
      for (int r = 0; r < 4; r++)
         p[r][0] = w[r][0] ^ sbox(p[2'(r + 1)][3]) ^ ((r == 0) ? rc : 8'h00);
      return p;
   endfunction

   aes_inv_round u_round (
      .state      (st_q),
      .rk         (rk_q),
      .last       (rnd_q == 4'd0),
      .next_state (round_out)
   );

   assign in_ready_w    = ready_q && (fsm_q == IDLE);
   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = (fsm_q == DONE);
   assign bus.plaintext = pt_q;
   assign dbg_state     = fsm_q;

   always_comb begin
      fsm_d = fsm_q;
      st_d  = st_q;
      rk_d  = rk_q;
      rnd_d = rnd_q;
      pt_d  = pt_q;
      unique case (fsm_q)
         IDLE: begin
            if (bus.in_valid && in_ready_w) begin
               st_d  = bus.ciphertext ^ bus.last_key;
               rk_d  = inv_key_step(bus.last_key, RCON[4'(NR)]);
               rnd_d = 4'(NR - 1);
               fsm_d = ROUND;
            end
         end
         ROUND: begin
            if (rnd_q != 4'd0) begin
               st_d  = round_out;
               rk_d  = inv_key_step(rk_q, RCON[rnd_q]);
               rnd_d = rnd_q - 4'd1;
            end else begin
               pt_d  = round_out;
               fsm_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q   <= IDLE;
         ready_q <= 1'b0;
         st_q    <= '0;
         rk_q    <= '0;
         rnd_q   <= '0;
         pt_q    <= '0;
      end else begin
         fsm_q   <= fsm_d;
         ready_q <= 1'b1;
         st_q    <= st_d;
         rk_q    <= rk_d;
         rnd_q   <= rnd_d;
         pt_q    <= pt_d;
      end
   end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 known answers, handshake corner cases, and a
// random stream checked against an independent forward AES-128 encryption model.
module tb_aes_inv_cipher_iter;
   import aes_pkg::*;

   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] LK1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] LKB = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk;
   logic         rst;
   fsm_t         dbg_state;
   int           total = 0;
   int           bad   = 0;
   logic [127:0] exp_q[$];
   logic [7:0]   sb [256];

   aes_inv_cipher_iter_if bus ();

   aes_inv_cipher_iter dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish (total=%0d bad=%0d)", total, bad);
      $fatal(1, "watchdog expired");
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model (forward AES-128) ----------------
   function automatic logic [7:0] m_xt(input logic [7:0] a);
      logic [7:0] s;
      s = {a[6:0], 1'b0};
      return a[7] ? (s ^ 8'h1b) : s;
   endfunction

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         p = m_xt(p);
         if (b[i]) p = p ^ a;
      end
      return p;
   endfunction

   // S-box from its definition: brute-force field inverse, then the FIPS affine transform.
   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] c;
      c = 8'h63;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (m_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^
                   inv[(i + 7) % 8] ^ c[i];
         sb[a] = s;
      end
   endtask

   function automatic state_t h2s(input logic [127:0] h);
      state_t s;
      for (int n = 0; n < 16; n++) s[n % 4][n / 4] = h[127 - 8 * n -: 8];
      return s;
   endfunction

   function automatic logic [127:0] s2h(input state_t s);
      logic [127:0] h;
      for (int n = 0; n < 16; n++) h[127 - 8 * n -: 8] = s[n % 4][n / 4];
      return h;
   endfunction

   task automatic model_encrypt(input logic [127:0] key, input logic [127:0] pt,
                                output logic [127:0] lk, output logic [127:0] ct);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      state_t      s;
      state_t      u;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i - 1];
         if (i % 4 == 0) begin
            t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
            rc = m_xt(rc);
         end
         w[i] = w[i - 4] ^ t;
      end
      s = h2s(pt) ^ h2s({w[0], w[1], w[2], w[3]});
      for (int rd = 1; rd <= 10; rd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               u[r][c] = sb[s[r][(c + r) % 4]];
         if (rd < 10) begin
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++)
                  s[r][c] = m_mul(8'h02, u[r][c]) ^ m_mul(8'h03, u[(r + 1) % 4][c]) ^
                            u[(r + 2) % 4][c] ^ u[(r + 3) % 4][c];
         end else begin
            s = u;
         end
         s = s ^ h2s({w[4 * rd], w[4 * rd + 1], w[4 * rd + 2], w[4 * rd + 3]});
      end
      lk = {w[40], w[41], w[42], w[43]};
      ct = s2h(s);
   endtask

   // ---------------- driver tasks (called at a falling edge) ----------------
   task automatic send(input logic [127:0] ct, input logic [127:0] lk);
      int g;
      g = 0;
      bus.in_valid   = 1'b1;
      bus.ciphertext = h2s(ct);
      bus.last_key   = h2s(lk);
      while (bus.in_ready !== 1'b1 && g < 200) begin
         @(negedge clk);
         g++;
      end
      check("send_accept", bus.in_ready, 1'b1);
      @(negedge clk);
      bus.in_valid   = 1'b0;
      bus.ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.last_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_vec(input string tag, input logic [127:0] ct, input logic [127:0] lk,
                          input logic [127:0] pt);
      int n;
      send(ct, lk);
      wait_out(n);
      check({tag, "_latency"}, n, 10);
      check({tag, "_ov"}, bus.out_valid, 1'b1);
      check({tag, "_pt"}, s2h(bus.plaintext), pt);
      @(negedge clk);
      check({tag, "_ov_low"}, bus.out_valid, 1'b0);
      check({tag, "_idle_rdy"}, bus.in_ready, 1'b1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int got;
      build_sbox();
      rst            = 1'b0;
      bus.in_valid   = 1'b0;
      bus.ciphertext = '0;
      bus.last_key   = '0;
      bus.out_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_plaintext", s2h(bus.plaintext), 128'h0);
      check("rst_state", dbg_state, IDLE);
      rst = 1'b1;
      #1;
      check("release_in_ready", bus.in_ready, 1'b0);
      @(negedge clk);
      check("first_edge_in_ready", bus.in_ready, 1'b1);

      // known answers; out_ready is already high before out_valid
      bus.out_ready = 1'b1;
      run_vec("c1", CT1, LK1, PT1);
      run_vec("appb", CTB, LKB, PTB);

      // backpressure for 20 cycles
      bus.out_ready = 1'b0;
      send(CT1, LK1);
      wait_out(n);
      check("bp_latency", n, 10);
      for (int i = 0; i < 20; i++) begin
         check("bp_pt", s2h(bus.plaintext), PT1);
         check("bp_ov", bus.out_valid, 1'b1);
         check("bp_in_ready", bus.in_ready, 1'b0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_idle", dbg_state, IDLE);
      check("bp_ov_low", bus.out_valid, 1'b0);

      // a second block offered while busy must be ignored
      send(CT1, LK1);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         bus.in_valid   = 1'b1;
         bus.ciphertext = h2s(CTB);
         bus.last_key   = h2s(LKB);
         check("busy_in_ready", bus.in_ready, 1'b0);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      wait_out(n);
      check("busy_ov", bus.out_valid, 1'b1);
      check("busy_pt", s2h(bus.plaintext), PT1);
      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         check("busy_no_extra", bus.out_valid, 1'b0);
         @(negedge clk);
      end

      // reset while rnd == 5
      send(CT1, LK1);
      repeat (4) @(negedge clk);
      check("mid_in_round", dbg_state, ROUND);
      rst = 1'b0;
      #1;
      check("mid_rst_ov", bus.out_valid, 1'b0);
      check("mid_rst_in_ready", bus.in_ready, 1'b0);
      check("mid_rst_state", dbg_state, IDLE);
      check("mid_rst_pt", s2h(bus.plaintext), 128'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_release_in_ready", bus.in_ready, 1'b0);
      @(negedge clk);
      check("mid_edge_in_ready", bus.in_ready, 1'b1);
      for (int i = 0; i < 12; i++) begin
         check("mid_no_pulse", bus.out_valid, 1'b0);
         @(negedge clk);
      end
      run_vec("c1_after_rst", CT1, LK1, PT1);

      // random stream with random in_valid gaps and out_ready stalls
      got = 0;
      fork
         begin : producer
            logic [127:0] key;
            logic [127:0] pt;
            logic [127:0] lk;
            logic [127:0] ct;
            for (int i = 0; i < 100; i++) begin
               key = {$urandom(), $urandom(), $urandom(), $urandom()};
               pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
               model_encrypt(key, pt, lk, ct);
               exp_q.push_back(pt);
               repeat ($urandom_range(0, 3)) @(negedge clk);
               send(ct, lk);
            end
         end
         begin : consumer
            int           cyc;
            logic [127:0] e;
            cyc = 0;
            while (got < 100 && cyc < 6000) begin
               bus.out_ready = ($urandom_range(0, 2) != 0);
               if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                  e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                  check("stream_pt", s2h(bus.plaintext), e);
                  got++;
               end
               @(negedge clk);
               cyc++;
            end
         end
      join
      check("stream_count", got, 100);
      check("stream_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
